// File: rtl/nios2_cordic_irq_ctrl.sv
// Avalon-MM interrupt controller: edge/level source latching, software mask,
// lowest-index vector, and a single irq line with re-assertion hold-off.
module nios2_cordic_irq_ctrl #(
   parameter int          NUM_SRC   = 8,
   parameter logic [15:0] EDGE_MASK = 16'h0001
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   input  logic [NUM_SRC-1:0] irq_src,
   output logic               irq
);

   localparam logic [NUM_SRC-1:0] EDGE = EDGE_MASK[NUM_SRC-1:0];

   typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;

   state_t             state;
   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] pend_edge;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] active;
   logic [NUM_SRC-1:0] w1c_clr;
   logic [NUM_SRC-1:0] edge_set;
   logic [15:0]        holdoff;
   logic [15:0]        hold_cnt;
   logic [15:0]        rd_mux;
   logic [3:0]         vec_idx;
   logic               wr;

   assign wr      = chipselect && !write_n;
   // Level bits track the registered input directly; only edge bits are latched.
   assign pending = (pend_edge & EDGE) | (src_q & ~EDGE);
   assign active  = pending & mask;

   assign w1c_clr  = (wr && address == 3'd0) ? (writedata[NUM_SRC-1:0] & EDGE) : '0;
   assign edge_set = (irq_src & ~src_q & EDGE)
                   | ((wr && address == 3'd5) ? (writedata[NUM_SRC-1:0] & EDGE) : '0);

   always_comb begin
      vec_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (active[i]) vec_idx = 4'(i);
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         3'd0:    rd_mux = 16'(pending);
         3'd1:    rd_mux = 16'(mask);
         3'd2:    rd_mux = 16'(active);
         3'd3:    rd_mux = {|active, 11'b0, vec_idx};
         3'd4:    rd_mux = holdoff;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         irq       <= 1'b0;
         src_q     <= '0;
         pend_edge <= '0;
         mask      <= '0;
         holdoff   <= '0;
         hold_cnt  <= '0;
         readdata  <= '0;
      end else begin
         src_q     <= irq_src;
         // Set is OR'd after the clear so a simultaneous edge survives W1C.
         pend_edge <= (pend_edge & ~w1c_clr) | edge_set;
         readdata  <= rd_mux;
         if (wr && address == 3'd1) mask    <= writedata[NUM_SRC-1:0];
         if (wr && address == 3'd4) holdoff <= writedata;

         case (state)
            IDLE: begin
               if (|active) begin
                  state <= ASSERT;
                  irq   <= 1'b1;
               end
            end
            ASSERT: begin
               if (active == '0) begin
                  irq <= 1'b0;
                  if (holdoff == 16'd0) begin
                     state <= IDLE;
                  end else begin
                     state    <= HOLD;
                     hold_cnt <= holdoff;
                  end
               end
            end
            HOLD: begin
               hold_cnt <= hold_cnt - 16'd1;
               if (hold_cnt <= 16'd1) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               irq   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nios2_cordic_irq_ctrl.sv
// Scoreboard bench: stimulus pushes expected {readdata, irq} per cycle from a
// behavioural model; a monitor pops and compares one time unit after each edge.
module tb_nios2_cordic_irq_ctrl;

   localparam int          NS   = 8;
   localparam logic [15:0] EDGE = 16'h00F1;
   localparam logic [15:0] SM   = 16'h00FF;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic [NS-1:0] irq_src;
   logic        irq;

   nios2_cordic_irq_ctrl #(.NUM_SRC(NS), .EDGE_MASK(EDGE)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .irq_src(irq_src), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] rd;
      logic        irq;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Reference model state
   logic [15:0] m_pend_e, m_srcq, m_mask, m_hold;
   logic        m_irq;
   int          m_quiet;
   logic [7:0]  cur_src;

   function automatic logic [3:0] lowest(input logic [15:0] v);
      logic [3:0] r = 4'd0;
      logic       found = 1'b0;
      for (int i = 0; i < 16; i++)
         if (v[i] && !found) begin
            r = 4'(i);
            found = 1'b1;
         end
      return r;
   endfunction

   function automatic logic [15:0] regread(input logic [2:0] a, input logic [15:0] pv,
                                           input logic [15:0] act, input logic [15:0] msk,
                                           input logic [15:0] hld);
      case (a)
         3'd0:    return pv;
         3'd1:    return msk;
         3'd2:    return act;
         3'd3:    return (act != 0) ? {1'b1, 11'b0, lowest(act)} : 16'h0;
         3'd4:    return hld;
         default: return 16'h0;
      endcase
   endfunction

   task automatic step(input logic [2:0] a, input logic cs, input logic wn,
                       input logic [15:0] wd, input logic rst);
      logic [15:0] pv, act, src16, clr, set;
      logic        w;
      exp_t        e;
      address    = a;
      chipselect = cs;
      write_n    = wn;
      writedata  = wd;
      irq_src    = cur_src;
      reset      = rst;
      src16 = {8'h0, cur_src};
      pv    = (m_pend_e & EDGE) | (m_srcq & ~EDGE & SM);
      act   = pv & m_mask;
      if (rst) begin
         e.rd = 16'h0;
         m_pend_e = 0; m_srcq = 0; m_mask = 0; m_hold = 0; m_irq = 0; m_quiet = 0;
      end else begin
         e.rd = regread(a, pv, act, m_mask, m_hold);
         w = cs && !wn;
         // irq drops when nothing is active, then stays quiet for HOLDOFF
         // cycles plus one idle cycle before it may rise again.
         if (m_irq) begin
            if (act == 0) begin
               m_irq   = 1'b0;
               m_quiet = int'(m_hold);
            end
         end else if (m_quiet > 0) begin
            m_quiet--;
         end else begin
            m_irq = (act != 0);
         end
         clr = (w && a == 3'd0) ? (wd & EDGE) : 16'h0;
         set = (src16 & ~m_srcq & EDGE) | ((w && a == 3'd5) ? (wd & EDGE) : 16'h0);
         m_pend_e = (m_pend_e & ~clr) | set;
         if (w && a == 3'd1) m_mask = wd & SM;
         if (w && a == 3'd4) m_hold = wd;
         m_srcq = src16;
      end
      e.irq = m_irq;
      q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic rd(input logic [2:0] a);
      step(a, 1'b0, 1'b1, 16'h0, 1'b0);
   endtask

   task automatic wrt(input logic [2:0] a, input logic [15:0] d);
      step(a, 1'b1, 1'b0, d, 1'b0);
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (readdata !== e.rd) begin
               errors++;
               $display("FAIL readdata cyc=%0d addr=%0d got=%h exp=%h", cyc, address, readdata, e.rd);
            end
            checks++;
            if (irq !== e.irq) begin
               errors++;
               $display("FAIL irq cyc=%0d got=%b exp=%b", cyc, irq, e.irq);
            end
         end
      end
   end

   initial begin
      cur_src = 8'h0;
      m_pend_e = 0; m_srcq = 0; m_mask = 0; m_hold = 0; m_irq = 0; m_quiet = 0;

      // Reset and read every address
      step(3'd0, 1'b0, 1'b1, 16'h0, 1'b1);
      step(3'd0, 1'b0, 1'b1, 16'h0, 1'b1);
      for (int i = 0; i < 8; i++) rd(3'(i));

      // Timer edge pulse, vector, W1C
      wrt(3'd1, 16'h0001);
      rd(3'd0);
      cur_src = 8'h01; rd(3'd0);
      cur_src = 8'h00; rd(3'd0);
      rd(3'd3); rd(3'd0); rd(3'd2);
      wrt(3'd0, 16'h0001);
      rd(3'd0); rd(3'd3); rd(3'd0);

      // Level source 3: W1C ignored, drop releases irq
      wrt(3'd1, 16'h0008);
      cur_src = 8'h08; rd(3'd3);
      rd(3'd3); rd(3'd3);
      wrt(3'd0, 16'h0008);
      rd(3'd0); rd(3'd3);
      cur_src = 8'h00; rd(3'd0);
      rd(3'd3); rd(3'd3);

      // Edge and W1C in the same cycle: set wins
      wrt(3'd1, 16'h0001);
      cur_src = 8'h01; rd(3'd0);
      cur_src = 8'h00; rd(3'd0); rd(3'd0);
      cur_src = 8'h01; wrt(3'd0, 16'h0001);
      cur_src = 8'h00; rd(3'd0); rd(3'd0);
      wrt(3'd0, 16'h0001);
      rd(3'd0); rd(3'd0);

      // Hold-off with edges every 3 cycles, each cleared immediately
      wrt(3'd4, 16'd5);
      for (int k = 0; k < 10; k++) begin
         cur_src = 8'h01; rd(3'd3);
         cur_src = 8'h00; wrt(3'd0, 16'h0001);
         rd(3'd4);
      end
      for (int k = 0; k < 8; k++) rd(3'd0);

      // FORCE then reset while asserted
      wrt(3'd4, 16'd0);
      wrt(3'd0, 16'h00FF);
      rd(3'd0); rd(3'd0);
      wrt(3'd5, 16'h0001);
      rd(3'd2); rd(3'd3);
      step(3'd1, 1'b0, 1'b1, 16'h0, 1'b1);
      rd(3'd1); rd(3'd1);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [2:0] op;
         for (int b = 0; b < NS; b++)
            if ($urandom_range(0, 7) == 0) cur_src[b] = ~cur_src[b];
         op = 3'($urandom_range(0, 7));
         case (op)
            3'd0, 3'd1: rd(3'($urandom_range(0, 7)));
            3'd2: wrt(3'd0, 16'($urandom));
            3'd3: wrt(3'd1, 16'($urandom));
            3'd4: wrt(3'd4, 16'($urandom_range(0, 6)));
            3'd5: wrt(3'd5, 16'($urandom) & 16'h0011);
            3'd6: begin
               if ($urandom_range(0, 1) == 0) wrt(3'($urandom_range(6, 7)), 16'($urandom));
               else step(3'($urandom_range(0, 5)), 1'b0, 1'b0, 16'($urandom), 1'b0);
            end
            default: begin
               if ($urandom_range(0, 19) == 0) step(3'd0, 1'b0, 1'b1, 16'h0, 1'b1);
               else rd(3'($urandom_range(0, 4)));
            end
         endcase
      end

      rd(3'd0);
      #10;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d exp=0 entries left", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nios2_cordic_irq_ctrl.md
# nios2_cordic_irq_ctrl

Avalon-MM interrupt controller sitting directly downstream of the interval timer and other peripheral IRQ lines in the nios2_cordic system. It latches up to 16 interrupt sources as edge- or level-triggered, applies a software mask, and reports the lowest-numbered active source as a vector. It drives one coalesced `irq` line to the Nios II, with a programmable hold-off that rate-limits re-assertion.

## Interface
- `NUM_SRC`, 8: number of interrupt sources, legal range 1..16.
- `EDGE_MASK`, 16'h0001: bit i=1 makes source i edge-triggered (rising); 0 makes it level-triggered. Bit 0 is the timer line.
- `clk` input 1: system clock; single clock domain.
- `reset` input 1: synchronous, active-high reset.
- `address` input 3: register select.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe.
- `writedata` input 16: write data.
- `readdata` output 16: registered read data.
- `irq_src` input NUM_SRC: raw interrupt inputs, synchronous to `clk`.
- `irq` output 1: interrupt request to the CPU, active-high.

## Operation
- Write strobe: `chipselect && !write_n`. Reads have no strobe: `readdata <= mux(address)` every cycle.
- `src_q <= irq_src` every cycle.
- Edge source i: `pending[i]` sets on `irq_src[i] & ~src_q[i]`.
- Level source i: `pending[i] = src_q[i]`; writes to a level bit are ignored.
- `active = pending & mask`.
- Register map (bits above NUM_SRC-1 read 0):
  - 0 PENDING: read `pending`. Write-1-to-clear on edge bits.
  - 1 MASK: read/write, reset 0.
  - 2 ACTIVE: read-only `active`.
  - 3 VECTOR: read-only. Bit 15 = |active; bits 3:0 = index of the lowest set active bit, 0 when none.
  - 4 HOLDOFF: read/write 16-bit cycle count, reset 0.
  - 5 FORCE: write-1 sets the corresponding edge `pending` bits; reads 0.
  - 6, 7: read 0; writes ignored.
- Edge set and W1C clear of the same bit in the same cycle: set wins, bit stays 1.
- State machine, `irq = (state == ASSERT)`:
  - IDLE: when |active, go to ASSERT next cycle.
  - ASSERT: when active == 0, go to HOLD, loading `hold_cnt <= HOLDOFF`. If HOLDOFF == 0, go directly to IDLE.
  - HOLD: decrement `hold_cnt`; go to IDLE when it reaches 1. Pending bits keep accumulating but `irq` stays low.
- Writes to HOLDOFF during HOLD do not affect the count in progress.
- Clearing MASK during ASSERT makes active 0, so the controller leaves ASSERT exactly as a clear would.
- NUM_SRC < 16: unused internal bits are tied 0 and do not participate in the vector.

## Timing
- Reset (synchronous): `readdata` = 0, `irq` = 0, state IDLE. `pending`, `src_q`, MASK, HOLDOFF and `hold_cnt` are all cleared.
- Reset asserted mid-ASSERT or mid-HOLD: `irq` is 0 the cycle after the reset edge.
- Source to irq latency:
  - `irq_src` rises before edge k: `src_q`/`pending` are 1 after edge k.
  - If unmasked, state is ASSERT and `irq` = 1 after edge k+1, so 2 cycles.
- Clear to irq low: a W1C write at edge k clears `pending` after k; `irq` drops after edge k+1.
- Hold-off: with HOLDOFF = N ≥ 1, `irq` is low for at least N+1 cycles between assertions. That is N cycles in HOLD plus 1 cycle in IDLE.
- Read latency: `readdata` reflects the `address` presented at edge k, valid after edge k.
- Register writes take effect on the edge they are sampled.

## Test plan
- Reset, then read all 8 addresses -> all return 0, `irq` = 0.
- MASK = 0x0001, pulse `irq_src[0]` high for 1 cycle at edge 10 -> `irq` = 1 after edge 11. PENDING = 0x0001, VECTOR = 0x8000. Write PENDING = 0x0001 -> `irq` = 0 two edges later.
- Level source 3 (EDGE_MASK = 0x0001), MASK = 0x0008, hold `irq_src[3]` high -> VECTOR = 0x8003. W1C of bit 3 has no effect. Drop `irq_src[3]` -> `irq` low 2 cycles later.
- Edge on source 0 in the same cycle as W1C of bit 0 -> PENDING stays 0x0001 and `irq` stays asserted.
- HOLDOFF = 5, timer edges every 3 cycles, each cleared immediately -> `irq` low for ≥ 6 cycles between pulses. Latched pending re-asserts `irq` right after HOLD ends.
- FORCE = 0x0001 with MASK = 0x0001 -> `irq` = 1 two cycles later. Assert `reset` while in ASSERT -> `irq` = 0, MASK = 0 next cycle.
